pcam: RTL and testbench

PCAM -- requirements
Module: pcam

---
 rtl/pcam_if.sv | 45 ++++
 rtl/pcam.sv | 149 ++++++++++++++
 tb/tb_pcam.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pcam_if.sv
// pcam_if -- request/response bundle for the pcam content-addressable store.
//
// Signals (widths follow the parameters):
//   ena        block enable; low makes the cycle a no-op
//   wr_en      write/allocate din
//   del_en     invalidate every entry equal to din
//   srch_en    search for din
//   din        operand for write/delete/search
//   rsp_valid  one-cycle pulse: search result registers updated
//   match_vec  per-entry match of the last executed search
//   hit        last search matched at least one entry
//   hit_addr   lowest matching index of the last search, 0 on miss
//   wr_dup     one-cycle pulse: write suppressed as a duplicate
//   count      number of valid entries
//   full       count == DEPTH
//
// Modports: master drives requests, slave (the pcam) drives responses.
interface pcam_if #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              ena;
  logic              wr_en;
  logic              del_en;
  logic              srch_en;
  logic [DATA_W-1:0] din;
  logic              rsp_valid;
  logic [DEPTH-1:0]  match_vec;
  logic              hit;
  logic [ADDR_W-1:0] hit_addr;
  logic              wr_dup;
  logic [ADDR_W:0]   count;
  logic              full;

  modport master (
    output ena, wr_en, del_en, srch_en, din,
    input  rsp_valid, match_vec, hit, hit_addr, wr_dup, count, full
  );

  modport slave (
    input  ena, wr_en, del_en, srch_en, din,
    output rsp_valid, match_vec, hit, hit_addr, wr_dup, count, full
  );
endinterface

// File: rtl/pcam.sv
// pcam -- small fully-associative store of DATA_W-bit words with
// write/allocate, delete-by-value and registered search.
//
// Ports:
//   clk   sole clock, all state updates on its rising edge
//   rst   synchronous active-high reset
//   bus   pcam_if.slave: requests in (ena/wr_en/del_en/srch_en/din),
//         responses out (rsp_valid/match_vec/hit/hit_addr/wr_dup/count/full)
//
// One operation per cycle, priority write > delete > search. Writes of a
// value already present are suppressed and flagged on wr_dup. When every
// entry is valid a new write overwrites the entry at the round-robin
// replacement pointer, which moves only on such overwrites.
module pcam #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic   clk,
  input  logic   rst,
  pcam_if.slave  bus
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  // Storage and state
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_rp;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic [DEPTH-1:0]  r_match_vec;
  logic              r_hit;
  logic [ADDR_W-1:0] r_hit_addr;
  logic              r_rsp_valid;
  logic              r_wr_dup;

  // Per-entry compare against the operand
  logic [DEPTH-1:0]  w_match;
  logic              w_any_match;
  logic [ADDR_W-1:0] w_match_idx;
  logic [ADDR_W-1:0] w_free_idx;
  logic              w_has_free;
  logic [ADDR_W:0]   w_del_cnt;
  logic [ADDR_W:0]   w_count_nxt;

  // Decoded operation for this cycle
  logic w_do_wr;
  logic w_do_del;
  logic w_do_srch;
  logic w_wr_new;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign w_match[g] = r_valid[g] && (r_data[g] == bus.din);
  end

  assign w_any_match = |w_match;
  assign w_del_cnt   = (ADDR_W+1)'($countones(w_match));

  // Priority encoders: scanning from the top down leaves the lowest index.
  // NOTE: every signal written in an always_comb gets a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    w_match_idx = '0;
    w_free_idx  = '0;
    w_has_free  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_match_idx = ADDR_W'(i);
      end
      if (!r_valid[i]) begin
        w_free_idx = ADDR_W'(i);
        w_has_free = 1'b1;
      end
    end
  end

  assign w_do_wr   = bus.ena && bus.wr_en;
  assign w_do_del  = bus.ena && !bus.wr_en && bus.del_en;
  assign w_do_srch = bus.ena && !bus.wr_en && !bus.del_en && bus.srch_en;
  assign w_wr_new  = w_do_wr && !w_any_match;

  // Count changes only on an allocating write or a delete that hits.
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_new && w_has_free) begin
      w_count_nxt = r_count + (ADDR_W+1)'(1);
    end else if (w_do_del) begin
      w_count_nxt = r_count - w_del_cnt;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data array is cleared on reset as well as the valid bits,
      // so the whole store returns to a known all-zero image.
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
      r_valid     <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_match_vec <= '0;
      r_hit       <= 1'b0;
      r_hit_addr  <= '0;
      r_rsp_valid <= 1'b0;
      r_wr_dup    <= 1'b0;
    end else begin
      r_rsp_valid <= w_do_srch;
      r_wr_dup    <= w_do_wr && w_any_match;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == FULL_COUNT);

      if (w_wr_new) begin
        if (w_has_free) begin
          r_data[w_free_idx]  <= bus.din;
          r_valid[w_free_idx] <= 1'b1;
        end else begin
          // Store is full: the entry under rp is valid and gets replaced.
          r_data[r_rp] <= bus.din;
          r_rp         <= r_rp + ADDR_W'(1);
        end
      end

      if (w_do_del) begin
        r_valid <= r_valid & ~w_match;
      end

      // Result registers hold until the next executed search.
      if (w_do_srch) begin
        r_match_vec <= w_match;
        r_hit       <= w_any_match;
        r_hit_addr  <= w_match_idx;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.match_vec = r_match_vec;
  assign bus.hit       = r_hit;
  assign bus.hit_addr  = r_hit_addr;
  assign bus.wr_dup    = r_wr_dup;
  assign bus.count     = r_count;
  assign bus.full      = r_full;

endmodule

// File: tb/tb_pcam.sv
// tb_pcam -- directed, table-driven bench for pcam (DATA_W=7, DEPTH=16).
// Each vector is one clock: inputs driven at the falling edge, outputs
// compared 1 time unit after the following rising edge.
module tb_pcam;

  localparam int DATA_W = 7;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    OP_IDLE, OP_WR, OP_DEL, OP_SRCH, OP_ALL, OP_OFF_WR, OP_OFF_SRCH, OP_DEL_SRCH
  } op_t;

  typedef struct {
    op_t               op;
    logic [DATA_W-1:0] din;
    logic              rsp;
    logic              hit;
    logic [ADDR_W-1:0] addr;
    logic [DEPTH-1:0]  mv;
    logic              dup;
    logic [ADDR_W:0]   cnt;
    logic              full;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  pcam_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  pcam #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input op_t op, input logic [DATA_W-1:0] din,
                              input logic rsp, input logic hit,
                              input logic [ADDR_W-1:0] addr, input logic [DEPTH-1:0] mv,
                              input logic dup, input logic [ADDR_W:0] cnt, input logic full);
    vec_t v;
    v.op = op; v.din = din; v.rsp = rsp; v.hit = hit; v.addr = addr;
    v.mv = mv; v.dup = dup; v.cnt = cnt; v.full = full;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(v.rsp));
    check({tag, ".hit"},       32'(bus.hit),       32'(v.hit));
    check({tag, ".hit_addr"},  32'(bus.hit_addr),  32'(v.addr));
    check({tag, ".match_vec"}, 32'(bus.match_vec), 32'(v.mv));
    check({tag, ".wr_dup"},    32'(bus.wr_dup),    32'(v.dup));
    check({tag, ".count"},     32'(bus.count),     32'(v.cnt));
    check({tag, ".full"},      32'(bus.full),      32'(v.full));
  endtask

  task automatic drive(input op_t op, input logic [DATA_W-1:0] din);
    bus.ena     = !(op == OP_OFF_WR || op == OP_OFF_SRCH);
    bus.wr_en   = (op == OP_WR || op == OP_ALL || op == OP_OFF_WR);
    bus.del_en  = (op == OP_DEL || op == OP_ALL || op == OP_DEL_SRCH);
    bus.srch_en = (op == OP_SRCH || op == OP_ALL || op == OP_OFF_SRCH || op == OP_DEL_SRCH);
    bus.din     = din;
  endtask

  task automatic run(input string tag, input vec_t v);
    @(negedge clk);
    drive(v.op, v.din);
    @(posedge clk);
    #1;
    check_outputs(tag, v);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(OP_IDLE, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    drive(OP_IDLE, '0);

    // Basic table: after reset the store is empty.
    tbl.push_back(mk(OP_SRCH,     7'h15, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 5'd0, 1'b0));
    tbl.push_back(mk(OP_WR,       7'h11, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 5'd1, 1'b0));
    tbl.push_back(mk(OP_WR,       7'h22, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 5'd2, 1'b0));
    tbl.push_back(mk(OP_WR,       7'h33, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 5'd3, 1'b0));
    tbl.push_back(mk(OP_SRCH,     7'h22, 1'b1, 1'b1, 4'd1, 16'h0002, 1'b0, 5'd3, 1'b0));
    tbl.push_back(mk(OP_WR,       7'h22, 1'b0, 1'b1, 4'd1, 16'h0002, 1'b1, 5'd3, 1'b0));
    tbl.push_back(mk(OP_IDLE,     7'h00, 1'b0, 1'b1, 4'd1, 16'h0002, 1'b0, 5'd3, 1'b0));
    tbl.push_back(mk(OP_DEL,      7'h22, 1'b0, 1'b1, 4'd1, 16'h0002, 1'b0, 5'd2, 1'b0));
    tbl.push_back(mk(OP_SRCH,     7'h22, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 5'd2, 1'b0));
    tbl.push_back(mk(OP_WR,       7'h44, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 5'd3, 1'b0));
    tbl.push_back(mk(OP_SRCH,     7'h44, 1'b1, 1'b1, 4'd1, 16'h0002, 1'b0, 5'd3, 1'b0));
    tbl.push_back(mk(OP_OFF_WR,   7'h55, 1'b0, 1'b1, 4'd1, 16'h0002, 1'b0, 5'd3, 1'b0));
    tbl.push_back(mk(OP_OFF_SRCH, 7'h11, 1'b0, 1'b1, 4'd1, 16'h0002, 1'b0, 5'd3, 1'b0));
    tbl.push_back(mk(OP_ALL,      7'h0A, 1'b0, 1'b1, 4'd1, 16'h0002, 1'b0, 5'd4, 1'b0));
    tbl.push_back(mk(OP_SRCH,     7'h0A, 1'b1, 1'b1, 4'd3, 16'h0008, 1'b0, 5'd4, 1'b0));
    tbl.push_back(mk(OP_DEL_SRCH, 7'h0A, 1'b0, 1'b1, 4'd3, 16'h0008, 1'b0, 5'd3, 1'b0));
    tbl.push_back(mk(OP_SRCH,     7'h0A, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 5'd3, 1'b0));
    tbl.push_back(mk(OP_DEL,      7'h77, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 5'd3, 1'b0));
    tbl.push_back(mk(OP_SRCH,     7'h11, 1'b1, 1'b1, 4'd0, 16'h0001, 1'b0, 5'd3, 1'b0));

    // Reset state
    apply_reset();
    #1;
    check_outputs("reset", mk(OP_IDLE, 7'h00, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 5'd0, 1'b0));

    foreach (tbl[i]) begin
      run($sformatf("v%0d", i), tbl[i]);
    end

    // Fill to full; the first write lands on the first edge after reset.
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      run($sformatf("fill%0d", i),
          mk(OP_WR, 7'(i), 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 5'(i + 1), 1'(i == DEPTH - 1)));
    end
    run("srch_top", mk(OP_SRCH, 7'h0F, 1'b1, 1'b1, 4'd15, 16'h8000, 1'b0, 5'd16, 1'b1));

    // Full overwrites walk the replacement pointer from entry 0.
    run("ow50",     mk(OP_WR,   7'h50, 1'b0, 1'b1, 4'd15, 16'h8000, 1'b0, 5'd16, 1'b1));
    run("srch00",   mk(OP_SRCH, 7'h00, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 5'd16, 1'b1));
    run("srch50",   mk(OP_SRCH, 7'h50, 1'b1, 1'b1, 4'd0,  16'h0001, 1'b0, 5'd16, 1'b1));
    run("ow60",     mk(OP_WR,   7'h60, 1'b0, 1'b1, 4'd0,  16'h0001, 1'b0, 5'd16, 1'b1));
    run("srch01",   mk(OP_SRCH, 7'h01, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 5'd16, 1'b1));
    run("srch60",   mk(OP_SRCH, 7'h60, 1'b1, 1'b1, 4'd1,  16'h0002, 1'b0, 5'd16, 1'b1));
    run("dup60",    mk(OP_WR,   7'h60, 1'b0, 1'b1, 4'd1,  16'h0002, 1'b1, 5'd16, 1'b1));
    run("ow61",     mk(OP_WR,   7'h61, 1'b0, 1'b1, 4'd1,  16'h0002, 1'b0, 5'd16, 1'b1));
    run("srch61",   mk(OP_SRCH, 7'h61, 1'b1, 1'b1, 4'd2,  16'h0004, 1'b0, 5'd16, 1'b1));
    run("srch02",   mk(OP_SRCH, 7'h02, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 5'd16, 1'b1));
    for (int k = 3; k < DEPTH; k++) begin
      run($sformatf("ow_k%0d", k),
          mk(OP_WR, 7'(8'h20 + k), 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 5'd16, 1'b1));
    end
    // Pointer has wrapped back to entry 0.
    run("ow70",     mk(OP_WR,   7'h70, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 5'd16, 1'b1));
    run("srch50b",  mk(OP_SRCH, 7'h50, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 5'd16, 1'b1));
    run("srch70",   mk(OP_SRCH, 7'h70, 1'b1, 1'b1, 4'd0,  16'h0001, 1'b0, 5'd16, 1'b1));
    run("srch2f",   mk(OP_SRCH, 7'h2F, 1'b1, 1'b1, 4'd15, 16'h8000, 1'b0, 5'd16, 1'b1));

    // Reset while full with a search request: the search is discarded.
    @(negedge clk);
    rst = 1'b1;
    drive(OP_SRCH, 7'h61);
    @(posedge clk);
    #1;
    check_outputs("rst_full", mk(OP_IDLE, 7'h00, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 5'd0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    run("post_rst61", mk(OP_SRCH, 7'h61, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 5'd0, 1'b0));
    run("post_rst00", mk(OP_SRCH, 7'h00, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 5'd0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
